// File: rtl/console_pkg.sv
// console_pkg: shared FSM encoding and constants for the console UART receiver
package console_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  localparam logic [31:0] DEFAULT_DIV = 32'd53333;
  localparam logic [31:0] MIN_DIV = 32'd4;
  localparam logic [31:0] RX_EMPTY_WORD = 32'hFFFF_FFFF;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: 2**AW x 8 synchronous FIFO, first-word-fall-through head, push+pop allowed when full
module byte_fifo #(
  parameter int AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  logic [7:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic rd, wr;
  always_comb begin
    full = cnt[AW];
    empty = cnt == '0;
    rd = pop && !empty;
    wr = push && (!full || rd);
    dout = mem[rp];
  end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= rd ? rp + 1'b1 : rp;
      cnt <= cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
endmodule

// File: rtl/console_uart_rx.sv
// console_uart_rx: 8N1 console receiver with byte FIFO and div/dat registers; CONSOLE_UART_RX_ERRCNT_EN adds rx_errcnt
module console_uart_rx
  import console_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter logic [31:0] DEF_DIV = DEFAULT_DIV,
  parameter logic [31:0] CLAMP_DIV = MIN_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_re,
  output logic [31:0] reg_dat_do,
  output logic        rx_valid,
  output logic        rx_overrun,
  input  logic        rx_overrun_clr
`ifdef CONSOLE_UART_RX_ERRCNT_EN
  , output logic [7:0] rx_errcnt
`endif
);
  rx_state_t state, state_d;
  logic s1, rx;
  logic [31:0] frame_div, cnt;
  logic [2:0] bitn;
  logic [7:0] shreg, head;
  logic tick_half, tick_full, push, err, full, empty, pop;
  always_comb begin
    tick_half = cnt == (frame_div >> 1);
    tick_full = cnt == frame_div - 32'd1;
    state_d = state;
    push = 1'b0;
    err = 1'b0;
    case (state)
      IDLE: state_d = rx ? IDLE : START;
      START: if (tick_half) begin
        state_d = rx ? IDLE : DATA;
        err = rx;
      end
      DATA: state_d = (tick_full && bitn == 3'd7) ? STOP : DATA;
      STOP: if (tick_full) begin
        state_d = rx ? IDLE : BREAK;
        push = rx;
        err = !rx;
      end
      BREAK: state_d = rx ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
    pop = reg_dat_re && !empty;
    rx_valid = !empty;
    reg_dat_do = empty ? RX_EMPTY_WORD : {24'b0, head};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b1;
      rx <= 1'b1;
      state <= IDLE;
      reg_div_do <= DEF_DIV;
      frame_div <= DEF_DIV;
      cnt <= '0;
      bitn <= '0;
      shreg <= '0;
      rx_overrun <= 1'b0;
    end else begin
      s1 <= ser_rx;
      rx <= s1;
      state <= state_d;
      for (int i = 0; i < 4; i++)
        if (reg_div_we[i]) reg_div_do[8*i +: 8] <= reg_div_di[8*i +: 8];
      if (state == IDLE && !rx) frame_div <= reg_div_do < CLAMP_DIV ? CLAMP_DIV : reg_div_do;
      cnt <= (state_d != state || (state == DATA && tick_full)) ? '0 : cnt + 32'd1;
      if (state == START) bitn <= '0;
      if (state == DATA && tick_full) begin
        shreg[bitn] <= rx;
        bitn <= bitn + 3'd1;
      end
      rx_overrun <= (push && full && !pop) ? 1'b1 : rx_overrun_clr ? 1'b0 : rx_overrun;
    end
`ifdef CONSOLE_UART_RX_ERRCNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) rx_errcnt <= '0;
    else rx_errcnt <= rx_overrun_clr ? 8'd0 : (err && rx_errcnt != 8'hFF) ? rx_errcnt + 8'd1 : rx_errcnt;
`endif
  byte_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(shreg),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
endmodule
